// File: rtl/sb_bus_arbiter.sv
// Two-requester round-robin arbiter in front of an iCE40 SB_* hard-IP system-bus port.
// Each transaction is a registered strobe held until SBACKi or until the timeout expires.
module sb_bus_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic       SBCLKi,
  input  logic       RST,
  input  logic       REQ0,
  input  logic       WR0,
  input  logic [7:0] ADR0,
  input  logic [7:0] WDAT0,
  output logic       ACK0,
  output logic       ERR0,
  input  logic       REQ1,
  input  logic       WR1,
  input  logic [7:0] ADR1,
  input  logic [7:0] WDAT1,
  output logic       ACK1,
  output logic       ERR1,
  output logic [7:0] RDAT,
  output logic       SBWRo,
  output logic       SBSTBo,
  output logic [7:0] SBADRo,
  output logic [7:0] SBDATo,
  input  logic       SBACKi,
  input  logic [7:0] SBDATi,
  output logic       BUSY,
  output logic [1:0] DBG_STATE
);

  // Requester handshake: REQx is a level held until a one-cycle ACKx or ERRx
  // pulse; the requester drops REQx the cycle after that pulse. Fields are
  // captured only on the grant edge.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_STB     = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  logic             r_grant;
  logic             r_last_grant;
  logic [CNT_W-1:0] r_cnt;
  logic             w_any_req;
  logic             w_pick1;

  // On a tie the requester that was not served last wins.
  assign w_any_req = REQ0 | REQ1;
  assign w_pick1   = REQ1 & (~REQ0 | ~r_last_grant);
  assign DBG_STATE = r_state;

  always_ff @(posedge SBCLKi or posedge RST) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      SBSTBo       <= 1'b0;
      SBWRo        <= 1'b0;
      SBADRo       <= 8'h00;
      SBDATo       <= 8'h00;
      RDAT         <= 8'h00;
      ACK0         <= 1'b0;
      ACK1         <= 1'b0;
      ERR0         <= 1'b0;
      ERR1         <= 1'b0;
      BUSY         <= 1'b0;
    end else begin
      ACK0 <= 1'b0;
      ACK1 <= 1'b0;
      ERR0 <= 1'b0;
      ERR1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_grant <= w_pick1;
            SBWRo   <= w_pick1 ? WR1   : WR0;
            SBADRo  <= w_pick1 ? ADR1  : ADR0;
            SBDATo  <= w_pick1 ? WDAT1 : WDAT0;
            SBSTBo  <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_STB;
            BUSY    <= 1'b1;
          end else begin
            BUSY <= 1'b0;
          end
        end
        S_STB: begin
          // An ACK arriving on the timeout edge still counts as success.
          if (SBACKi) begin
            SBSTBo       <= 1'b0;
            if (!SBWRo) RDAT <= SBDATi;
            ACK0         <= ~r_grant;
            ACK1         <= r_grant;
            r_last_grant <= r_grant;
            r_state      <= S_RELEASE;
          end else if (r_cnt == TMO_LAST) begin
            SBSTBo       <= 1'b0;
            ERR0         <= ~r_grant;
            ERR1         <= r_grant;
            r_last_grant <= r_grant;
            r_state      <= S_RELEASE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_RELEASE: begin
          r_state <= S_IDLE;
          BUSY    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          SBSTBo  <= 1'b0;
          BUSY    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sb_bus_arbiter.sv
// Bench for sb_bus_arbiter: directed vector table, hand-written reset sequence and
// randomized transactions checked against a transaction-level arbitration model.
module tb_sb_bus_arbiter;

  localparam int TIMEOUT = 16;
  localparam int EW      = 35;

  logic       SBCLKi;
  logic       RST;
  logic       REQ0, WR0, REQ1, WR1;
  logic [7:0] ADR0, WDAT0, ADR1, WDAT1;
  logic       ACK0, ERR0, ACK1, ERR1;
  logic [7:0] RDAT;
  logic       SBWRo, SBSTBo, SBACKi, BUSY;
  logic [7:0] SBADRo, SBDATo, SBDATi;
  logic [1:0] DBG_STATE;

  sb_bus_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .SBCLKi(SBCLKi), .RST(RST),
    .REQ0(REQ0), .WR0(WR0), .ADR0(ADR0), .WDAT0(WDAT0), .ACK0(ACK0), .ERR0(ERR0),
    .REQ1(REQ1), .WR1(WR1), .ADR1(ADR1), .WDAT1(WDAT1), .ACK1(ACK1), .ERR1(ERR1),
    .RDAT(RDAT), .SBWRo(SBWRo), .SBSTBo(SBSTBo), .SBADRo(SBADRo), .SBDATo(SBDATo),
    .SBACKi(SBACKi), .SBDATi(SBDATi), .BUSY(BUSY), .DBG_STATE(DBG_STATE)
  );

  // clock / reset
  initial SBCLKi = 1'b0;
  always #5 SBCLKi = ~SBCLKi;

  int n_tests = 0;
  int n_fail  = 0;
  // record: {id, is_ack, bus[16:0], rdat[7:0], strobe_len[7:0]}
  logic [EW-1:0] exp_q[$];

  typedef struct {
    logic       r0, r1;
    logic       w0; logic [7:0] a0, d0;
    logic       w1; logic [7:0] a1, d1;
    int         dly;
    logic [7:0] ipd;
    logic       e_id, e_ack;
    logic [7:0] e_rdat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // driver + monitor for one transaction; the IP model raises SBACKi once the
  // strobe has been high for dly+1 observed cycles, and toggles it randomly
  // while the strobe is low (the arbiter must ignore that).
  task automatic run_txn(input logic r0, input logic r1,
                         input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                         input logic w1, input logic [7:0] a1, input logic [7:0] d1,
                         input int dly, input logic [7:0] ipd,
                         input logic e_id, input logic e_ack, input logic [7:0] e_rdat,
                         input string tag);
    logic [EW-1:0] rec;
    logic [16:0]   bus;
    int            slen;
    int            elen;
    bit            done;
    elen = e_ack ? dly + 1 : TIMEOUT;
    bus  = e_id ? {w1, a1, d1} : {w0, a0, d0};
    exp_q.push_back({e_id, e_ack, bus, e_rdat, 8'(elen)});
    REQ0 = r0; WR0 = w0; ADR0 = a0; WDAT0 = d0;
    REQ1 = r1; WR1 = w1; ADR1 = a1; WDAT1 = d1;
    SBDATi = ipd;
    slen = 0;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge SBCLKi);
      if (SBSTBo) begin
        slen++;
        chk({tag, " bus_fields"}, 64'({SBWRo, SBADRo, SBDATo}), 64'(bus));
        if (slen == 1) begin
          if (e_id) begin
            WR1 = 1'($urandom); ADR1 = 8'($urandom); WDAT1 = 8'($urandom);
          end else begin
            WR0 = 1'($urandom); ADR0 = 8'($urandom); WDAT0 = 8'($urandom);
          end
        end
        SBACKi = (slen == dly + 1);
      end else begin
        SBACKi = 1'($urandom_range(0, 1));
      end
      if (ACK0 | ACK1 | ERR0 | ERR1) begin
        rec = exp_q.pop_front();
        chk({tag, " pulses"}, 64'({ACK0, ACK1, ERR0, ERR1}),
            64'({rec[33] & ~rec[34], rec[33] & rec[34], ~rec[33] & ~rec[34], ~rec[33] & rec[34]}));
        chk({tag, " rdat"}, 64'(RDAT), 64'(rec[15:8]));
        chk({tag, " strobe_len"}, 64'(slen), 64'(rec[7:0]));
        chk({tag, " stb_busy_at_done"}, 64'({SBSTBo, BUSY}), 64'(2'b01));
        done = 1'b1;
      end
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s no_completion: got none expected ACK/ERR within 300 cycles", tag);
      exp_q.delete();
    end
    if (e_id) REQ1 = 1'b0;
    else      REQ0 = 1'b0;
    @(negedge SBCLKi);
    SBACKi = 1'($urandom_range(0, 1));
    chk({tag, " release_gap"}, 64'({SBSTBo, BUSY, ACK0, ACK1, ERR0, ERR1, RDAT}),
        64'({6'b000000, e_rdat}));
  endtask

  bit         p0, p1, win, ea;
  logic       f0w, f1w, m_last, wwr;
  logic [7:0] f0a, f0d, f1a, f1d, m_rdat, ipd, erd;
  int         dly;

  initial begin
    RST = 1'b0; REQ0 = 0; REQ1 = 0; WR0 = 0; WR1 = 0; ADR0 = 0; ADR1 = 0;
    WDAT0 = 0; WDAT1 = 0; SBACKi = 0; SBDATi = 0;

    //                r0 r1 w0 a0     d0     w1 a1     d1     dly ipd    id ack rdat
    vecs[0]  = '{1, 1, 1, 8'h10, 8'h11, 1, 8'h20, 8'h21, 0,  8'h00, 0, 1, 8'h00};
    vecs[1]  = '{1, 1, 1, 8'h11, 8'h12, 1, 8'h20, 8'h21, 1,  8'h00, 1, 1, 8'h00};
    vecs[2]  = '{1, 1, 1, 8'h11, 8'h12, 1, 8'h22, 8'h23, 3,  8'h00, 0, 1, 8'h00};
    vecs[3]  = '{0, 1, 1, 8'h00, 8'h00, 1, 8'h22, 8'h23, 0,  8'h00, 1, 1, 8'h00};
    vecs[4]  = '{1, 0, 1, 8'h09, 8'h0F, 0, 8'h00, 8'h00, 2,  8'h00, 0, 1, 8'h00};
    vecs[5]  = '{0, 1, 0, 8'h00, 8'h00, 0, 8'h0C, 8'h00, 1,  8'hA5, 1, 1, 8'hA5};
    vecs[6]  = '{1, 0, 0, 8'h30, 8'h00, 0, 8'h00, 8'h00, 20, 8'h3C, 0, 0, 8'hA5};
    vecs[7]  = '{0, 1, 0, 8'h00, 8'h00, 0, 8'h31, 8'h00, 15, 8'h5A, 1, 1, 8'h5A};
    vecs[8]  = '{1, 0, 0, 8'h32, 8'h00, 0, 8'h00, 8'h00, 14, 8'h66, 0, 1, 8'h66};
    vecs[9]  = '{0, 1, 0, 8'h00, 8'h00, 0, 8'h33, 8'h00, 16, 8'h77, 1, 0, 8'h66};
    vecs[10] = '{1, 1, 1, 8'h40, 8'h41, 1, 8'h50, 8'h51, 4,  8'h00, 0, 1, 8'h66};
    vecs[11] = '{1, 1, 1, 8'h42, 8'h43, 1, 8'h50, 8'h51, 2,  8'h00, 1, 1, 8'h66};

    #1 RST = 1'b1;
    repeat (2) @(negedge SBCLKi);
    chk("reset_ctrl", 64'({SBSTBo, SBWRo, ACK0, ACK1, ERR0, ERR1, BUSY}), 64'(0));
    chk("reset_data", 64'({SBADRo, SBDATo, RDAT}), 64'(0));
    chk("reset_state", 64'(DBG_STATE), 64'(0));
    RST = 1'b0;

    for (int i = 0; i < 12; i++)
      run_txn(vecs[i].r0, vecs[i].r1, vecs[i].w0, vecs[i].a0, vecs[i].d0,
              vecs[i].w1, vecs[i].a1, vecs[i].d1, vecs[i].dly, vecs[i].ipd,
              vecs[i].e_id, vecs[i].e_ack, vecs[i].e_rdat, $sformatf("vec%0d", i));

    // randomized transactions against the round-robin model
    m_last = 1'b1; m_rdat = 8'h66; p0 = 0; p1 = 0;
    for (int t = 0; t < 150; t++) begin
      if (!p0 && $urandom_range(0, 1) == 1) begin
        p0 = 1; f0w = 1'($urandom); f0a = 8'($urandom); f0d = 8'($urandom);
      end
      if (!p1 && $urandom_range(0, 1) == 1) begin
        p1 = 1; f1w = 1'($urandom); f1a = 8'($urandom); f1d = 8'($urandom);
      end
      if (!p0 && !p1) begin
        p0 = 1; f0w = 1'($urandom); f0a = 8'($urandom); f0d = 8'($urandom);
      end
      win = (p0 && p1) ? ~m_last : p1;
      dly = ($urandom_range(0, 3) == 0) ? int'($urandom_range(TIMEOUT - 2, TIMEOUT + 2))
                                        : int'($urandom_range(0, 5));
      ipd = 8'($urandom);
      ea  = (dly <= TIMEOUT - 1);
      wwr = win ? f1w : f0w;
      erd = (ea && !wwr) ? ipd : m_rdat;
      run_txn(p0, p1, f0w, f0a, f0d, f1w, f1a, f1d, dly, ipd, win, ea, erd,
              $sformatf("rand%0d", t));
      m_last = win;
      m_rdat = erd;
      if (win) p1 = 0;
      else     p0 = 0;
    end

    // reset in the middle of a strobe: strobe drops at once, nothing reported
    REQ1 = 0; REQ0 = 1; WR0 = 1; ADR0 = 8'h77; WDAT0 = 8'h88; SBACKi = 0;
    repeat (4) @(negedge SBCLKi);
    chk("pre_reset_stb", 64'({SBSTBo, BUSY}), 64'(2'b11));
    #2 RST = 1'b1;
    #1;
    chk("async_reset_stb", 64'({SBSTBo, BUSY, ACK0, ACK1, ERR0, ERR1}), 64'(0));
    chk("async_reset_state", 64'({DBG_STATE, RDAT}), 64'(0));
    REQ0 = 0;
    repeat (2) @(negedge SBCLKi);
    chk("reset_no_pulse", 64'({ACK0, ACK1, ERR0, ERR1, SBSTBo}), 64'(0));
    RST = 1'b0;
    run_txn(1, 1, 1, 8'h01, 8'h02, 1, 8'h03, 8'h04, 1, 8'h00, 0, 1, 8'h00, "post_reset_tie");
    run_txn(0, 1, 1, 8'h00, 8'h00, 0, 8'h05, 8'h00, 0, 8'hC3, 1, 1, 8'hC3, "post_reset_r1");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
